wordle_scorer: RTL
==================

Name: wordle_scorer

Overview:
- Downstream of the Wordle guess state machine, upstream of the VGA colour-array renderer.
- Takes a submitted 5-letter guess and the secret word, both ASCII, and produces one 3-bit RGB colour per letter plus a win flag.
- Uses the two-pass algorithm so duplicate letters score correctly:
  - pass 1 marks greens and counts the unmatched secret letters;
  - pass 2 awards yellows against those counts.
- Start/Ack handshake in the same style as the keyboard and state machine blocks.

Parameters:
- GREEN, 3'b010, colour code for correct letter, correct position
- YELLOW, 3'b110, colour code for letter present elsewhere
- WHITE, 3'b111, colour code for letter absent
- CNT_W, 3, width of each per-letter count (max 5 occurrences)

Ports:
- Clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- Start  input  1  single-cycle request to score; sampled only in QI
- Ack  input  1  releases QD back to QI
- guess  input  40  guess word, [39:32] = first letter ... [7:0] = fifth letter
- secret  input  40  secret word, same packing
- colors  output  15  [14:12] = first letter colour ... [2:0] = fifth letter colour
- win  output  1  1 when all five letters are GREEN
- q_I, q_Green, q_Yellow, q_Done  output  1 each  one-hot state flags
- busy  output  1  q_Green | q_Yellow

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on `reset`.
- Reset values: state QI, colors = 15'h0000 (black = unscored), win = 0, index i = 0, all 26 letter counts = 0.
- Letter index: code − 8'h41. Only 'A'..'Z' (8'h41..8'h5A) are letters. Any other byte is never counted, never yellow, and scores WHITE unless it byte-equals the secret character, in which case it scores GREEN.
- QI:
  - Start = 1 on a clock edge: latch guess and secret into internal registers, clear all counts, clear colors and win, set i = 0, go to QGreen.
  - Ack is ignored in QI.
- QGreen (exactly 5 cycles, i = 0..4, i = 0 is the MSB byte):
  - If g[i] == s[i]: colors[i] = GREEN and set the internal green flag gm[i].
  - Else: colors[i] = WHITE (provisional). If s[i] is a letter, count[s[i]] += 1.
  - At i = 4: set i = 0 and go to QYellow.
- QYellow (exactly 5 cycles, i = 0..4):
  - If !gm[i] and g[i] is a letter and count[g[i]] != 0: colors[i] = YELLOW, count[g[i]] −= 1.
  - Otherwise colors[i] is unchanged.
  - Decrements take effect the next cycle and are visible to later positions. One count read and at most one write per cycle.
  - At i = 4: win <= &gm, go to QDone.
- QDone:
  - colors and win hold stable.
  - Ack = 1: go to QI; colors and win keep their values until the next accepted Start.
- Latency: Start edge to first cycle of q_Done = 11 edges (1 capture + 5 + 5).
- Simultaneous and boundary events:
  - Start outside QI is ignored, including Start and Ack together in QDone: Ack wins and Start is dropped.
  - Input guess/secret may change freely after the capture edge; the block works only from latched copies.
  - Reset asserted mid-pass: immediate return to QI with reset values; no partial colours survive.
  - Count saturation cannot occur (at most 5 increments, CNT_W = 3).

Optional Feature:
- Macro: SCORER_CASEFOLD_EN
- Defined: lowercase 'a'..'z' (8'h61..8'h7A) in guess and secret are folded to uppercase at the capture edge, before comparison and counting. "crane" versus "CRANE" scores all GREEN, win = 1.
- Undefined: no folding. Lowercase bytes are non-letters per the rules above. "crane" versus "CRANE" scores all WHITE, win = 0.

Test Plan:
- Exact match:
  - secret "CRANE", guess "CRANE", Start pulse → q_Done 11 cycles after Start, colors = {GREEN ×5} = 15'b010010010010010, win = 1.
  - Then Ack → q_I = 1, colors unchanged.
- Duplicate letters:
  - secret "ABBEY", guess "BABES" → colors = YELLOW, YELLOW, GREEN, GREEN, WHITE = 15'b110110010010111, win = 0.
- Excess guess duplicates:
  - secret "SPEED", guess "EERIE" → YELLOW, YELLOW, WHITE, WHITE, WHITE = 15'b110110111111111.
  - The third E is WHITE because the E count is exhausted.
- Start while busy:
  - Start pulsed again at cycle 4 of QGreen with a different guess → ignored; result matches the first guess; QDone still at cycle 11.
- Reset mid-operation:
  - reset driven 0 during QYellow cycle 2 → q_I = 1, colors = 0, win = 0 asynchronously.
  - After release, a fresh Start gives a correct full result.
- Casefold:
  - secret "CRANE", guess "crane" → all GREEN / win = 1 with SCORER_CASEFOLD_EN defined.
  - All WHITE / win = 0 without it.

Source files
------------

// File: rtl/wordle_scorer_if.sv
// -----------------------------------------------------------------------------
// wordle_scorer_if
// Handshake and data bundle between the Wordle guess state machine (master)
// and the scorer (slave).
//   Start, Ack       : request / release handshake from the state machine
//   guess, secret    : 5 ASCII bytes each, first letter in [39:32]
//   colors, win      : per-letter 3-bit RGB result and all-green flag
//   q_I .. q_Done    : one-hot state flags of the scorer
//   busy             : scorer is in one of its two scoring passes
// -----------------------------------------------------------------------------
interface wordle_scorer_if;
   logic        Start;
   logic        Ack;
   logic [39:0] guess;
   logic [39:0] secret;
   logic [14:0] colors;
   logic        win;
   logic        q_I;
   logic        q_Green;
   logic        q_Yellow;
   logic        q_Done;
   logic        busy;

   modport master (
      output Start, Ack, guess, secret,
      input  colors, win, q_I, q_Green, q_Yellow, q_Done, busy
   );

   modport slave (
      input  Start, Ack, guess, secret,
      output colors, win, q_I, q_Green, q_Yellow, q_Done, busy
   );
endinterface

// File: rtl/wordle_scorer.sv
// -----------------------------------------------------------------------------
// wordle_scorer
// Scores a 5-letter ASCII guess against the secret word with the two-pass
// algorithm: pass 1 (QGreen) marks exact matches and counts the unmatched
// secret letters, pass 2 (QYellow) hands out yellows against those counts so
// duplicate letters score correctly. One position is handled per clock.
//
// Ports:
//   Clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : wordle_scorer_if.slave (Start/Ack, guess/secret, colors/win,
//            one-hot state flags, busy)
//
// Optional feature (macro SCORER_CASEFOLD_EN): when defined, lowercase bytes
// of guess and secret are folded to uppercase as they are captured.
// -----------------------------------------------------------------------------
module wordle_scorer #(
   parameter logic [2:0] GREEN  = 3'b010,
   parameter logic [2:0] YELLOW = 3'b110,
   parameter logic [2:0] WHITE  = 3'b111,
   parameter int         CNT_W  = 3
) (
   input logic           Clk,
   input logic           reset,
   wordle_scorer_if.slave bus
);

   typedef enum logic [1:0] {QI, QGREEN, QYELLOW, QDONE} state_t;

   state_t           state, state_nxt;
   logic [7:0]       g_q [5];
   logic [7:0]       s_q [5];
   logic [2:0]       col_q [5];
   logic [CNT_W-1:0] cnt_q [26];
   logic [4:0]       gm_q;
   logic [2:0]       i_q;
   logic             win_q;

   logic [7:0]       cur_g, cur_s, rd_byte;
   logic             green_hit, rd_letter, yel_hit, last;
   logic [4:0]       rd_idx;
   logic [CNT_W-1:0] rd_cnt;

   function automatic logic is_letter(input logic [7:0] b);
      return (b >= 8'h41) && (b <= 8'h5A);
   endfunction

   function automatic logic [4:0] letter_idx(input logic [7:0] b);
      logic [7:0] d;
      d = b - 8'h41;
      return d[4:0];
   endfunction

   function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef SCORER_CASEFOLD_EN
      if ((b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
`endif
      return b;
   endfunction

   // Single count port: pass 1 addresses by the secret byte, pass 2 by the guess byte.
   always_comb begin
      cur_g     = g_q[i_q];
      cur_s     = s_q[i_q];
      green_hit = (cur_g == cur_s);
      rd_byte   = (state == QYELLOW) ? cur_g : cur_s;
      rd_letter = is_letter(rd_byte);
      rd_idx    = rd_letter ? letter_idx(rd_byte) : 5'd0;
      rd_cnt    = cnt_q[rd_idx];
      yel_hit   = !gm_q[i_q] && rd_letter && (rd_cnt != '0);
      last      = (i_q == 3'd4);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         QI:      if (bus.Start) state_nxt = QGREEN;
         QGREEN:  if (last)      state_nxt = QYELLOW;
         QYELLOW: if (last)      state_nxt = QDONE;
         QDONE:   if (bus.Ack)   state_nxt = QI;
         default:                state_nxt = QI;
      endcase
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) state <= QI;
      else        state <= state_nxt;
   end

   // Working copies of the words; the inputs may change after the capture edge.
   always_ff @(posedge Clk) begin
      if ((state == QI) && bus.Start) begin
         for (int k = 0; k < 5; k++) begin
            g_q[k] <= fold(bus.guess[39-8*k -: 8]);
            s_q[k] <= fold(bus.secret[39-8*k -: 8]);
         end
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         i_q   <= '0;
         win_q <= 1'b0;
         gm_q  <= '0;
         for (int k = 0; k < 5; k++)  col_q[k] <= '0;
         for (int j = 0; j < 26; j++) cnt_q[j] <= '0;
      end else begin
         case (state)
            QI: begin
               if (bus.Start) begin
                  i_q   <= '0;
                  win_q <= 1'b0;
                  gm_q  <= '0;
                  for (int k = 0; k < 5; k++)  col_q[k] <= '0;
                  for (int j = 0; j < 26; j++) cnt_q[j] <= '0;
               end
            end
            QGREEN: begin
               if (green_hit) begin
                  col_q[i_q] <= GREEN;
                  gm_q[i_q]  <= 1'b1;
               end else begin
                  col_q[i_q] <= WHITE;
                  if (rd_letter) cnt_q[rd_idx] <= rd_cnt + CNT_W'(1);
               end
               i_q <= last ? 3'd0 : i_q + 3'd1;
            end
            QYELLOW: begin
               if (yel_hit) begin
                  col_q[i_q]    <= YELLOW;
                  cnt_q[rd_idx] <= rd_cnt - CNT_W'(1);
               end
               if (last) begin
                  win_q <= &gm_q;
                  i_q   <= 3'd0;
               end else begin
                  i_q <= i_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.colors   = {col_q[0], col_q[1], col_q[2], col_q[3], col_q[4]};
   assign bus.win      = win_q;
   assign bus.q_I      = (state == QI);
   assign bus.q_Green  = (state == QGREEN);
   assign bus.q_Yellow = (state == QYELLOW);
   assign bus.q_Done   = (state == QDONE);
   assign bus.busy     = (state == QGREEN) || (state == QYELLOW);

endmodule
